eq_sweep_checker: RTL and testbench

- Sequential truth-table sweeper and equivalence checker for the two-variable gate-equivalence exercises.
- Drives every minterm index onto the shared inputs of two candidate implementations: a reference boolean expression and a gate-only (e.g. NAND-only) rewrite.
- Consumes both outputs, compares them per minterm, and reports a pass/fail verdict with mismatch count and first failing minterm.
- Replaces the hand-written for-loop stimulus with a clocked, reusable block.

---
 rtl/eq_sweep_checker.sv | 146 ++++++++++++++
 tb/tb_eq_sweep_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/eq_sweep_checker.sv
// rtl/eq_sweep_checker.sv - truth-table sweeper and equivalence checker for two candidate implementations
// Optional EQ_SWEEP_TRACE_EN: prints a per-minterm table and counts X/Z inputs as mismatches.
module eq_sweep_checker #(
   parameter int N      = 2,
   parameter int SETTLE = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         f_ref,
   input  logic         f_dut,
   output logic [N-1:0] m,
   output logic         busy,
   output logic         done,
   output logic         equal,
   output logic [N:0]   mism_cnt,
   output logic [N-1:0] first_bad,
   output logic         first_valid
);

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SAMPLE, S_DONE} state_t;

   localparam logic [3:0]   SETTLE_C = 4'(SETTLE);
   localparam logic [N-1:0] M_LAST   = '1;
   localparam logic [N-1:0] M_ONE    = 1;
   localparam logic [N:0]   CNT_ONE  = 1;

   state_t       r_state;
   state_t       w_next;
   logic [3:0]   r_hold;
   logic [N-1:0] r_m;
   logic [N:0]   r_mism;
   logic [N-1:0] r_first_bad;
   logic         r_first_valid;
   logic         r_equal;
   logic         w_busy;
   logic         w_done;
   logic         w_diff;
   logic [N:0]   w_mism_next;

`ifdef EQ_SWEEP_TRACE_EN
   assign w_diff = (f_ref !== f_dut);
`else
   assign w_diff = (f_ref != f_dut);
`endif

   always_comb begin
      w_mism_next = r_mism;
      if (w_diff) w_mism_next = r_mism + CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_HOLD;
         end
         S_HOLD: begin
            w_busy = 1'b1;
            if (r_hold == 4'd0) w_next = S_SAMPLE;
         end
         S_SAMPLE: begin
            w_busy = 1'b1;
            if (r_m == M_LAST) w_next = S_DONE;
            else               w_next = S_HOLD;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold        <= 4'd0;
         r_m           <= '0;
         r_mism        <= '0;
         r_first_bad   <= '0;
         r_first_valid <= 1'b0;
         r_equal       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_m           <= '0;
                  r_mism        <= '0;
                  r_first_bad   <= '0;
                  r_first_valid <= 1'b0;
                  r_equal       <= 1'b0;
                  r_hold        <= SETTLE_C;
`ifdef EQ_SWEEP_TRACE_EN
                  $display("minterm  m  f_ref f_dut result");
`endif
               end
            end
            S_HOLD: begin
               if (r_hold != 4'd0) r_hold <= r_hold - 4'd1;
            end
            S_SAMPLE: begin
`ifdef EQ_SWEEP_TRACE_EN
               $display("%7d  %b  %b     %b     %s", r_m, r_m, f_ref, f_dut, w_diff ? "DIFF" : "ok");
`endif
               if (w_diff) begin
                  r_mism <= w_mism_next;
                  if (!r_first_valid) begin
                     r_first_bad   <= r_m;
                     r_first_valid <= 1'b1;
                  end
               end
               // verdict is latched with the final count so it is valid during the DONE cycle
               if (r_m == M_LAST) begin
                  r_equal <= (w_mism_next == '0);
               end else begin
                  r_m    <= r_m + M_ONE;
                  r_hold <= SETTLE_C;
               end
            end
            S_DONE: begin
               r_m <= '0;
`ifdef EQ_SWEEP_TRACE_EN
               $display("sweep done: mism_cnt=%0d", r_mism);
`endif
            end
            default: ;
         endcase
      end
   end

   assign m           = r_m;
   assign busy        = w_busy;
   assign done        = w_done;
   assign equal       = r_equal;
   assign mism_cnt    = r_mism;
   assign first_bad   = r_first_bad;
   assign first_valid = r_first_valid;

endmodule

// File: tb/tb_eq_sweep_checker.sv
// tb/tb_eq_sweep_checker.sv - scoreboard bench for eq_sweep_checker (N=2/SETTLE=1 and N=3/SETTLE=0)
module tb_eq_sweep_checker;

   typedef struct {
      int mism;
      int fb;
      int fv;
      int eq;
      int busy_cycles;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_a, start_b;
   logic       f_ref_a, f_dut_a, f_ref_b, f_dut_b;
   logic [1:0] m_a, first_bad_a;
   logic [2:0] m_b, first_bad_b;
   logic [2:0] mism_a;
   logic [3:0] mism_b;
   logic       busy_a, done_a, equal_a, fv_a;
   logic       busy_b, done_b, equal_b, fv_b;
   int         mode = 0;
   int         sel = 0;
   int         n_vec = 0;
   int         n_bad = 0;
   exp_t       sb[$];

   int s_m, s_busy, s_done, s_eq, s_mism, s_fb, s_fv;

   always #5 clk = ~clk;

   eq_sweep_checker #(.N(2), .SETTLE(1)) u_a (
      .clk(clk), .reset(reset), .start(start_a), .f_ref(f_ref_a), .f_dut(f_dut_a),
      .m(m_a), .busy(busy_a), .done(done_a), .equal(equal_a), .mism_cnt(mism_a),
      .first_bad(first_bad_a), .first_valid(fv_a)
   );

   eq_sweep_checker #(.N(3), .SETTLE(0)) u_b (
      .clk(clk), .reset(reset), .start(start_b), .f_ref(f_ref_b), .f_dut(f_dut_b),
      .m(m_b), .busy(busy_b), .done(done_b), .equal(equal_b), .mism_cnt(mism_b),
      .first_bad(first_bad_b), .first_valid(fv_b)
   );

   function automatic logic ref_fn(input int which, input int i);
      logic [7:0] v;
      v = i[7:0];
      if (which != 0) return ^v[2:0];
      return ~v[1] | ~v[0];
   endfunction

   function automatic logic dut_fn(input int which, input int md, input int i);
      logic [7:0] v;
      v = i[7:0];
      if (which != 0) return ^v[2:0];
      case (md)
         1:       return v[1] & v[0];
         2:       return ~(v[1] | v[0]);
         default: return ~(v[1] & v[0]);
      endcase
   endfunction

   always_comb begin
      f_ref_a = ref_fn(0, int'(m_a));
      f_dut_a = dut_fn(0, mode, int'(m_a));
      f_ref_b = ref_fn(1, int'(m_b));
      f_dut_b = dut_fn(1, mode, int'(m_b));
   end

   always_comb begin
      s_m    = (sel != 0) ? int'(m_b)         : int'(m_a);
      s_busy = (sel != 0) ? int'(busy_b)      : int'(busy_a);
      s_done = (sel != 0) ? int'(done_b)      : int'(done_a);
      s_eq   = (sel != 0) ? int'(equal_b)     : int'(equal_a);
      s_mism = (sel != 0) ? int'(mism_b)      : int'(mism_a);
      s_fb   = (sel != 0) ? int'(first_bad_b) : int'(first_bad_a);
      s_fv   = (sel != 0) ? int'(fv_b)        : int'(fv_a);
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive_start(input logic v);
      if (sel != 0) start_b = v;
      else          start_a = v;
   endtask

   task automatic sweep(input int which, input int md, input bit poke);
      int   nb, s, nm, busy_n, merr;
      bit   seen_done, poked;
      exp_t e;
      sel  = which;
      mode = md;
      nb   = (which != 0) ? 3 : 2;
      s    = (which != 0) ? 0 : 1;
      nm   = 1 << nb;
      e    = '{0, 0, 0, 0, 0};
      for (int i = 0; i < nm; i++) begin
         if (ref_fn(which, i) != dut_fn(which, md, i)) begin
            if (e.mism == 0) begin
               e.fb = i;
               e.fv = 1;
            end
            e.mism++;
         end
      end
      e.eq          = (e.mism == 0) ? 1 : 0;
      e.busy_cycles = nm * (s + 2);
      sb.push_back(e);
      @(negedge clk);
      drive_start(1'b1);
      @(negedge clk);
      drive_start(1'b0);
      busy_n    = 0;
      merr      = 0;
      seen_done = 0;
      poked     = 0;
      for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
         drive_start(1'b0);
         if (s_busy != 0) begin
            if (s_m != busy_n / (s + 2)) merr++;
            busy_n++;
            if (poke && !poked && s_m == 1) begin
               drive_start(1'b1);
               poked = 1;
            end
         end
         if (s_done != 0) begin
            seen_done = 1;
            e = sb.pop_front();
            chk("busy_len", busy_n, e.busy_cycles);
            chk("m_seq_err", merr, 0);
            chk("m_last", s_m, nm - 1);
            chk("busy_in_done", s_busy, 0);
            chk("mism_cnt", s_mism, e.mism);
            chk("first_bad", s_fb, e.fb);
            chk("first_valid", s_fv, e.fv);
            chk("equal", s_eq, e.eq);
            if (poke) drive_start(1'b1);
         end
         @(negedge clk);
      end
      drive_start(1'b0);
      chk("done_seen", int'(seen_done), 1);
      chk("done_one_cycle", s_done, 0);
      chk("m_back_to_0", s_m, 0);
      chk("equal_holds", s_eq, e.eq);
      chk("mism_holds", s_mism, e.mism);
      @(negedge clk);
      chk("idle_no_restart", s_busy, 0);
   endtask

   initial begin
      int cnt;
      reset   = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_m", int'(m_a), 0);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_done", int'(done_a), 0);
      chk("rst_equal", int'(equal_a), 0);
      chk("rst_mism", int'(mism_a), 0);
      chk("rst_first_bad", int'(first_bad_a), 0);
      chk("rst_first_valid", int'(fv_a), 0);
      chk("rst_b_busy", int'(busy_b), 0);
      reset = 1'b0;
      @(negedge clk);

      sweep(0, 0, 0);
      sweep(0, 1, 0);
      sweep(0, 2, 0);
      sweep(1, 0, 0);

      sel  = 0;
      mode = 1;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int k = 0; k < 50 && m_a != 2'd2; k++) @(negedge clk);
      chk("rst_reach_m2", int'(m_a), 2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_m", int'(m_a), 0);
      chk("abort_busy", int'(busy_a), 0);
      chk("abort_mism", int'(mism_a), 0);
      cnt = 0;
      for (int k = 0; k < 30; k++) begin
         if (done_a) cnt++;
         @(negedge clk);
      end
      chk("abort_no_done", cnt, 0);

      sweep(0, 0, 0);
      sweep(0, 2, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
